mips_cpu_mem_arbiter: RTL and testbench

//  Shares the single Avalon-MM memory port (32-bit, byteenable, waitrequest, read latency 1) between the
//  CPU instruction-fetch port (read-only) and data port (read/write). Sits between the CPU core and RAM.
//  One transaction is outstanding at a time. Per-requester req/ack handshake returns read data.

---
 rtl/mips_cpu_mem_arb_pkg.sv | 21 ++
 rtl/mips_cpu_mem_arbiter_if.sv | 50 +++++
 rtl/mips_cpu_mem_arb_pick.sv | 41 ++++
 rtl/mips_cpu_mem_arbiter.sv | 109 ++++++++++
 tb/tb_mips_cpu_mem_arbiter.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_cpu_mem_arb_pkg.sv
// Shared types for the CPU memory-port arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : which requester owns the memory port
//   BE_ALL      : byteenable used for instruction fetches
package mips_cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    ACK     = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_INSTR = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/mips_cpu_mem_arbiter_if.sv
// Bus bundle between the CPU core ports, the arbiter and the Avalon-MM RAM port.
//   i_*   : instruction fetch req/ack port (read-only)
//   d_*   : data req/ack port (read/write, byteenable)
//   avm_* : Avalon-MM master port towards RAM (read latency 1)
// Modports: slave = arbiter view, master = CPU core + memory view.
interface mips_cpu_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [BE_W-1:0]   avm_byteenable;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;

  modport slave (
    input  i_req, i_addr,
    output i_ack, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_ack, d_rdata,
    output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    input  avm_waitrequest, avm_readdata
  );

  modport master (
    output i_req, i_addr,
    input  i_ack, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_ack, d_rdata,
    input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
    output avm_waitrequest, avm_readdata
  );
endinterface

// File: rtl/mips_cpu_mem_arb_pick.sv
// Combinational winner select for the memory-port arbiter.
// Build option: MIPS_CPU_MEM_ARB_RR_EN
//   defined   : round-robin, a tie goes to the requester that was not granted last
//   undefined : fixed priority, data beats instruction on a tie
// Ports:
//   i_ireq  : instruction request
//   i_dreq  : data request
//   i_last  : requester granted most recently
//   o_any   : at least one request pending
//   o_gnt   : winning requester (valid when o_any)
module mips_cpu_mem_arb_pick
  import mips_cpu_mem_arb_pkg::*;
(
  input  logic   i_ireq,
  input  logic   i_dreq,
  input  grant_t i_last,
  output logic   o_any,
  output grant_t o_gnt
);

`ifndef MIPS_CPU_MEM_ARB_RR_EN
  // last-grant only matters for round-robin
  logic w_last_unused;
  assign w_last_unused = i_last;
`endif

  always_comb begin
    o_any = i_ireq | i_dreq;
    o_gnt = GNT_INSTR;
    if (i_ireq && i_dreq) begin
`ifdef MIPS_CPU_MEM_ARB_RR_EN
      o_gnt = (i_last == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
`else
      o_gnt = GNT_DATA;
`endif
    end else if (i_dreq) begin
      o_gnt = GNT_DATA;
    end
  end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Shares one Avalon-MM memory port between the CPU fetch and data ports.
// One transaction outstanding; the winner's command is latched in IDLE, so
// requester changes while granted have no effect.
// Build option: MIPS_CPU_MEM_ARB_RR_EN selects round-robin arbitration
// (see mips_cpu_mem_arb_pick); default is data-over-instruction priority.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave modport of mips_cpu_mem_arbiter_if (i_*, d_*, avm_*)
// Latency without stall: write ack 2 cycles, read ack 3 cycles after req is
// sampled; each waitrequest cycle adds one.
module mips_cpu_mem_arbiter
  import mips_cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_cpu_mem_arbiter_if.slave  bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t        r_state;
  grant_t            r_gnt;
  grant_t            r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_irdata;
  logic [DATA_W-1:0] r_drdata;

  logic              w_any;
  grant_t            w_pick;
  logic              w_issue;

  mips_cpu_mem_arb_pick u_pick (
    .i_ireq (bus.i_req),
    .i_dreq (bus.d_req),
    .i_last (r_last),
    .o_any  (w_any),
    .o_gnt  (w_pick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_gnt    <= GNT_INSTR;
      r_last   <= GNT_INSTR;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_irdata <= '0;
      r_drdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= w_pick;
            r_state <= ISSUE;
            if (w_pick == GNT_DATA) begin
              r_we    <= bus.d_we;
              r_addr  <= bus.d_addr;
              r_wdata <= bus.d_wdata;
              r_be    <= bus.d_be;
            end else begin
              r_we    <= 1'b0;
              r_addr  <= bus.i_addr;
              r_wdata <= '0;
              r_be    <= {(BE_W/4){BE_ALL}};
            end
          end
        end
        ISSUE: begin
          if (!bus.avm_waitrequest)
            r_state <= r_we ? ACK : RD_WAIT;
        end
        RD_WAIT: begin
          // readdata valid exactly one cycle after the read was accepted
          if (r_gnt == GNT_DATA) r_drdata <= bus.avm_readdata;
          else                   r_irdata <= bus.avm_readdata;
          r_state <= ACK;
        end
        ACK: begin
          r_last  <= r_gnt;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // strobes are decoded from state so an async reset drops them immediately
  assign w_issue            = (r_state == ISSUE);
  assign bus.avm_read       = w_issue & ~r_we;
  assign bus.avm_write      = w_issue &  r_we;
  assign bus.avm_address    = r_addr;
  assign bus.avm_writedata  = r_wdata;
  assign bus.avm_byteenable = r_be;

  assign bus.i_ack   = (r_state == ACK) && (r_gnt == GNT_INSTR);
  assign bus.d_ack   = (r_state == ACK) && (r_gnt == GNT_DATA);
  assign bus.i_rdata = r_irdata;
  assign bus.d_rdata = r_drdata;

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
module tb_mips_cpu_mem_arbiter;
  import mips_cpu_mem_arb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_cpu_mem_arbiter_if bus ();

  mips_cpu_mem_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
  } txn_t;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          waits;
  } vec_t;

  txn_t sb_q[$];
  txn_t cmd_q[$];

  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  grant_t      model_last = GNT_INSTR;

  // ---------------- memory model ----------------
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2402_000A;
    return a ^ 32'h5A5A_5A5A;
  endfunction

  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic        acc_rd   = 1'b0;
  logic [31:0] acc_addr = '0;
  txn_t        cmd_c;

  assign bus.avm_waitrequest = (bus.avm_read | bus.avm_write) && (wait_cnt < wait_cfg);

  // command check + accept detection, sampled mid-cycle
  always @(negedge clk) begin
    acc_rd = 1'b0;
    if (!reset && (bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
      if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        cmd_c = cmd_q.pop_front();
        chk("cmd_addr", bus.avm_address, cmd_c.addr);
        chk("cmd_write", bus.avm_write, cmd_c.we);
        chk("cmd_read", bus.avm_read, !cmd_c.we);
        chk("cmd_be", bus.avm_byteenable, cmd_c.be);
        if (cmd_c.we) chk("cmd_wdata", bus.avm_writedata, cmd_c.wdata);
      end
      acc_rd   = bus.avm_read;
      acc_addr = bus.avm_address;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt         <= 0;
      bus.avm_readdata <= '0;
    end else begin
      if (bus.avm_read | bus.avm_write)
        wait_cnt <= bus.avm_waitrequest ? wait_cnt + 1 : 0;
      bus.avm_readdata <= acc_rd ? mem_fn(acc_addr) : 32'h0BAD_F00D;
    end
  end

  // ---------------- ack scoreboard ----------------
  txn_t ack_e;
  always @(negedge clk) begin
    if (!reset && (bus.i_ack || bus.d_ack)) begin
      if (bus.i_ack && bus.d_ack) chk("dual_ack", 1, 0);
      if (sb_q.size() == 0) chk("unexpected_ack", 1, 0);
      else begin
        ack_e = sb_q.pop_front();
        chk("ack_kind", bus.d_ack, ack_e.is_d);
        if (ack_e.is_d && !ack_e.we) exp_drd = ack_e.rdata;
        if (!ack_e.is_d)            exp_ird = ack_e.rdata;
        chk("i_rdata", bus.i_rdata, exp_ird);
        chk("d_rdata", bus.d_rdata, exp_drd);
      end
    end
  end

  function automatic grant_t model_pick(input bit ir, input bit dr, input grant_t last);
    if (ir && dr) begin
`ifdef MIPS_CPU_MEM_ARB_RR_EN
      return (last == GNT_INSTR) ? GNT_DATA : GNT_INSTR;
`else
      return GNT_DATA;
`endif
    end
    return dr ? GNT_DATA : GNT_INSTR;
  endfunction

  // single-requester transaction; entered and left at a negedge
  task automatic run_one(input vec_t v);
    txn_t e;
    int   cyc = 0;
    int   strb = 0;
    bit   got = 0;
    e.is_d  = v.is_d;
    e.we    = v.is_d & v.we;
    e.addr  = v.addr;
    e.wdata = v.wdata;
    e.be    = v.is_d ? v.be : 4'hF;
    e.rdata = mem_fn(v.addr);
    sb_q.push_back(e);
    cmd_q.push_back(e);
    wait_cfg = v.waits;
    if (v.is_d) begin
      bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata; bus.d_be = v.be;
      bus.d_req = 1'b1;
    end else begin
      bus.i_addr = v.addr;
      bus.i_req  = 1'b1;
    end
    while (!got && cyc < 50) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.avm_read || bus.avm_write) strb++;
      if (v.is_d ? bus.d_ack : bus.i_ack) got = 1;
    end
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    chk("ack_seen", got, 1);
    chk("latency", cyc, (e.we ? 2 : 3) + v.waits);
    chk("strobe_cycles", strb, 1 + v.waits);
    model_last = v.is_d ? GNT_DATA : GNT_INSTR;
  endtask

  // both requesters raised together; each keeps req high for n_held acks total
  task automatic both_seq(input int n_held, input int waits);
    localparam logic [31:0] IA = 32'h0040_0000;
    localparam logic [31:0] DA = 32'h1001_0000;
    grant_t order[$];
    bit     ir = 1;
    bit     dr = 1;
    grant_t last;
    grant_t w;
    txn_t   e;
    int     step = 0;
    int     acks = 0;
    int     cyc = 0;
    last = model_last;
    while (ir || dr) begin
      w = model_pick(ir, dr, last);
      order.push_back(w);
      last = w;
      step++;
      if (step >= n_held) begin
        if (w == GNT_DATA) dr = 0; else ir = 0;
      end
    end
    model_last = last;
    foreach (order[k]) begin
      e.is_d  = (order[k] == GNT_DATA);
      e.we    = 1'b0;
      e.addr  = e.is_d ? DA : IA;
      e.wdata = '0;
      e.be    = e.is_d ? 4'b0110 : 4'hF;
      e.rdata = mem_fn(e.addr);
      sb_q.push_back(e);
      cmd_q.push_back(e);
    end
    wait_cfg = waits;
    bus.i_addr = IA; bus.d_addr = DA; bus.d_we = 1'b0; bus.d_be = 4'b0110;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    while ((bus.i_req || bus.d_req) && cyc < 400) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (bus.i_ack || bus.d_ack) begin
        acks++;
        if (acks >= n_held) begin
          if (bus.d_ack) bus.d_req = 1'b0; else bus.i_req = 1'b0;
        end
      end
    end
    chk("both_done", !(bus.i_req || bus.d_req), 1);
    chk("both_acks", acks, order.size());
    bus.i_req = 1'b0; bus.d_req = 1'b0;
  endtask

  vec_t vecs[6];
  vec_t va;

  initial begin
    bus.i_req = 0; bus.i_addr = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;

    //        is_d we  addr           wdata          be       waits
    vecs[0] = '{1'b0, 1'b0, 32'hBFC0_0000, 32'h0,         4'b1111, 0};
    vecs[1] = '{1'b1, 1'b1, 32'hBFC0_0010, 32'hDEAD_BEEF, 4'b0011, 2};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1004, 32'h0,         4'b1100, 0};
    vecs[3] = '{1'b0, 1'b0, 32'hBFC0_0004, 32'h0,         4'b1111, 1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_2008, 32'hCAFE_F00D, 4'b1000, 0};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_200C, 32'h0,         4'b1111, 3};

    // reset state
    @(negedge clk);
    chk("rst_avm_read", bus.avm_read, 0);
    chk("rst_avm_write", bus.avm_write, 0);
    chk("rst_avm_address", bus.avm_address, 0);
    chk("rst_avm_be", bus.avm_byteenable, 0);
    chk("rst_avm_wdata", bus.avm_writedata, 0);
    chk("rst_i_ack", bus.i_ack, 0);
    chk("rst_d_ack", bus.d_ack, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_one(vecs[i]);
      @(negedge clk);
    end

    // simultaneous requests, each dropped after its own ack
    both_seq(1, 0);
    @(negedge clk);
    // both held for four transactions
    both_seq(4, 1);
    @(negedge clk);

    // reset while a write is stalled in ISSUE
    wait_cfg = 100;
    bus.d_we = 1'b1; bus.d_addr = 32'h0000_3000; bus.d_wdata = 32'h1122_3344; bus.d_be = 4'hF;
    bus.d_req = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("pre_rst_write", bus.avm_write, 1);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_write", bus.avm_write, 0);
    chk("rst_mid_read", bus.avm_read, 0);
    chk("rst_mid_d_ack", bus.d_ack, 0);
    bus.d_req = 1'b0;
    exp_ird = '0; exp_drd = '0; model_last = GNT_INSTR; wait_cfg = 0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_i_rdata", bus.i_rdata, 0);
    chk("post_rst_d_rdata", bus.d_rdata, 0);
    run_one(vecs[0]);
    @(negedge clk);

    // back-to-back fetches, req re-raised the cycle after ack
    va = '{1'b0, 1'b0, 32'h0040_0010, 32'h0, 4'hF, 0};
    run_one(va);
    @(negedge clk);
    chk("i_rdata_hold", bus.i_rdata, mem_fn(32'h0040_0010));
    va.addr = 32'h0040_0014;
    run_one(va);
    repeat (3) @(negedge clk);
    chk("i_rdata_final", bus.i_rdata, mem_fn(32'h0040_0014));

    repeat (4) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("cmd_drained", cmd_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

endmodule
